// File: rtl/avl_wb_bridge_if.sv
// Avalon-MM slave and Wishbone classic master signal bundle for avl_wb_bridge.
// The master modport is the bridge's view; slave is the view of the surrounding fabric/peripheral.
interface avl_wb_bridge_if #(
  parameter int AVL_AW = 5,
  parameter int WB_AW  = 3,
  parameter int WB_DW  = 8
);
  logic [AVL_AW-1:0]  avl_address;
  logic               avl_read;
  logic               avl_write;
  logic [31:0]        avl_writedata;
  logic [3:0]         avl_byteenable;
  logic               avl_waitrequest;
  logic [31:0]        avl_readdata;
  logic               avl_readdatavalid;
  logic [1:0]         avl_response;

  logic [WB_AW-1:0]   wb_adr_o;
  logic [WB_DW-1:0]   wb_dat_o;
  logic [WB_DW-1:0]   wb_dat_i;
  logic [WB_DW/8-1:0] wb_sel_o;
  logic               wb_we_o;
  logic               wb_cyc_o;
  logic               wb_stb_o;
  logic               wb_ack_i;
  logic               wb_err_i;

  modport master (
    input  avl_address, avl_read, avl_write, avl_writedata, avl_byteenable,
    output avl_waitrequest, avl_readdata, avl_readdatavalid, avl_response,
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    output avl_address, avl_read, avl_write, avl_writedata, avl_byteenable,
    input  avl_waitrequest, avl_readdata, avl_readdatavalid, avl_response,
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/avl_wb_bridge.sv
// Avalon-MM slave to Wishbone classic master bridge with one outstanding transaction,
// bus-error/timeout read responses and a locally synchronised reset.
module avl_wb_bridge #(
  parameter int AVL_AW  = 5,
  parameter int WB_AW   = 3,
  parameter int WB_DW   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic            clk_riscv,
  input  logic            rst_in,
  output logic            rst_sync_n_o,
  output logic            wb_rst_o,
  avl_wb_bridge_if.master bus
);

  localparam int SELW = WB_DW / 8;
  localparam int CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [CW-1:0] C_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] C_MAX  = '1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       r_sync;
  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WB_AW-1:0] r_adr;
  logic [WB_DW-1:0] r_dat;
  logic [SELW-1:0]  r_sel;
  logic             r_we;
  logic [WB_DW-1:0] r_rdData;
  logic [1:0]       r_rdResp;
  logic             r_rdValid;

  logic w_waitReq;
  logic w_accept;
  logic w_timeout;
  logic w_done;
  logic w_unused;

  // Assert asynchronously with rst_in, release two edges after it goes high
  always_ff @(posedge clk_riscv or negedge rst_in) begin
    if (!rst_in) r_sync <= 2'b00;
    else         r_sync <= {r_sync[0], 1'b1};
  end

  assign rst_sync_n_o = r_sync[1];
  assign wb_rst_o     = ~r_sync[1];

  assign w_waitReq = ~r_sync[1] | (r_state != S_IDLE);
  assign w_accept  = (bus.avl_read | bus.avl_write) & ~w_waitReq;
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == C_LAST);
  assign w_done    = bus.wb_err_i | bus.wb_ack_i | w_timeout;
  assign w_unused  = ^{bus.avl_address, bus.avl_writedata, bus.avl_byteenable};

  always_ff @(posedge clk_riscv or negedge rst_sync_n_o) begin
    if (!rst_sync_n_o) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_adr     <= '0;
      r_dat     <= '0;
      r_sel     <= '0;
      r_we      <= 1'b0;
      r_rdData  <= '0;
      r_rdResp  <= 2'b00;
      r_rdValid <= 1'b0;
    end else begin
      r_rdValid <= (r_state == S_RESP);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_adr   <= bus.avl_address[WB_AW+1:2];
            r_dat   <= bus.avl_writedata[WB_DW-1:0];
            r_sel   <= bus.avl_byteenable[SELW-1:0];
            r_we    <= bus.avl_write;
            r_cnt   <= '0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_cnt != C_MAX) r_cnt <= r_cnt + CW'(1);
          // Write completions carry no Avalon response, so errors/timeouts vanish here
          if (w_done) begin
            if (r_we) begin
              r_state <= S_IDLE;
            end else begin
              r_rdData <= (bus.wb_ack_i && !bus.wb_err_i) ? bus.wb_dat_i : '0;
              r_rdResp <= bus.wb_err_i ? 2'b10 : (bus.wb_ack_i ? 2'b00 : 2'b11);
              r_state  <= S_RESP;
            end
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.avl_waitrequest   = w_waitReq;
  assign bus.avl_readdatavalid = r_rdValid;
  assign bus.avl_readdata      = r_rdValid ? 32'(r_rdData) : 32'd0;
  assign bus.avl_response      = r_rdValid ? r_rdResp : 2'b00;

  assign bus.wb_adr_o = r_adr;
  assign bus.wb_dat_o = r_dat;
  assign bus.wb_sel_o = r_sel;
  assign bus.wb_we_o  = r_we;
  assign bus.wb_cyc_o = (r_state == S_BUSY);
  assign bus.wb_stb_o = (r_state == S_BUSY);

endmodule

// File: doc/avl_wb_bridge.md
Name: avl_wb_bridge

Overview:
- Parametrised Avalon-MM slave to Wishbone classic master bridge for low-speed peripherals (UART 16550, future I2C/SPI cores) on the clk_riscv domain, behind the Qsys interconnect.
- Successor to the hand-written single-UART glue, generalised in address width, data width and byte lanes.
- Adds a synchronised reset output, bus-error and timeout responses, and enforces a single outstanding transaction.

Parameters:
- AVL_AW, 5, Avalon byte-address width.
- WB_AW, 3, Wishbone word-address width; wb_adr_o = avl_address[WB_AW+1:2]; requires AVL_AW >= WB_AW+2.
- WB_DW, 8, Wishbone data width; legal values 8, 16, 32.
- TIMEOUT, 255, max wait cycles for wb_ack_i/wb_err_i; 0 disables the timeout.

Ports:
- clk_riscv  in  1  bridge clock.
- rst_in  in  1  reset, asynchronous, active-low.
- rst_sync_n_o  out  1  rst_in synchronised: asynchronous assert, 2-flop deassert.
- avl_address  in  AVL_AW  byte address.
- avl_read  in  1  read request.
- avl_write  in  1  write request.
- avl_writedata  in  32  write data.
- avl_byteenable  in  4  byte enables.
- avl_waitrequest  out  1  command stall.
- avl_readdata  out  32  read data, zero-extended above WB_DW.
- avl_readdatavalid  out  1  read data strobe.
- avl_response  out  2  00 OKAY, 10 SLVERR, 11 DECODEERROR.
- wb_rst_o  out  1  ~rst_sync_n_o.
- wb_adr_o  out  WB_AW  word address.
- wb_dat_o  out  WB_DW  = avl_writedata[WB_DW-1:0], captured.
- wb_dat_i  in  WB_DW  slave read data.
- wb_sel_o  out  WB_DW/8  = avl_byteenable[WB_DW/8-1:0], captured.
- wb_we_o  out  1  write enable.
- wb_cyc_o  out  1  cycle.
- wb_stb_o  out  1  strobe, identical to wb_cyc_o.
- wb_ack_i  in  1  slave acknowledge.
- wb_err_i  in  1  slave error.

Behaviour:
- Reset:
  - rst_in low clears immediately: the synchroniser, FSM (to IDLE), timeout counter and all outputs.
  - Reset output values: avl_waitrequest=1, wb_rst_o=1, all other outputs 0.
  - rst_sync_n_o rises on the 2nd clk_riscv rising edge after rst_in deasserts.
  - All other logic is held in reset by rst_sync_n_o.
- FSM states: IDLE, BUSY, RESP.
- avl_waitrequest = ~rst_sync_n_o | (state != IDLE).
- IDLE:
  - Command accepted on an edge where (avl_read|avl_write) & ~avl_waitrequest.
  - On accept, capture address, data, sel and we (we = avl_write); clear the counter; go to BUSY.
  - If avl_read and avl_write are both high, the write wins.
- BUSY:
  - wb_cyc_o = wb_stb_o = 1, with captured address, data, sel and we stable.
  - Counter increments each cycle.
  - Completion priority: wb_err_i > wb_ack_i > timeout (counter == TIMEOUT-1 with TIMEOUT != 0).
  - On completion, wb_cyc_o drops the next cycle.
  - Write completion: go to IDLE; writes produce no Avalon response; write errors and timeouts are silently dropped.
  - Read completion: capture readdata (wb_dat_i on ack, 0 on err or timeout) and response (00/10/11); go to RESP.
- RESP:
  - avl_readdatavalid = 1 for exactly one cycle; go to IDLE.
  - avl_readdata and avl_response are valid only while readdatavalid is high and return to 0 afterwards.
- Latency:
  - Read accepted at edge T, slave ack sampled at edge T+k (k >= 1): readdatavalid high in the cycle after edge T+k+1.
  - Next command is acceptable from edge T+k+2.
  - Write: next command is acceptable from edge T+k+1.
- Stray wb_ack_i or wb_err_i in IDLE or RESP: ignored.
- Reset mid-transaction: wb_cyc_o drops asynchronously; no readdatavalid is issued for the aborted read.
- Counter width is clog2(TIMEOUT+1); the counter saturates and never wraps.

Test Plan:
- Reset release: rst_in low for 3 cycles then high -> rst_sync_n_o high exactly 2 edges later; avl_waitrequest=1 and wb_cyc_o=0 throughout reset.
- Write, WB_DW=8: address 0x0C, writedata 0x000000A5, ack after 3 cycles -> wb_adr_o=3, wb_dat_o=0xA5, wb_sel_o=1, wb_we_o=1; wb_cyc_o high exactly 3 cycles; no readdatavalid.
- Read: address 0x14, wb_dat_i=0x5A acked on 1st BUSY cycle -> avl_readdata=0x0000005A with response 00; single readdatavalid pulse at T+3.
- Error and timeout, TIMEOUT=4: read with wb_err_i -> response 10, data 0. Read with no ack -> wb_cyc_o high 4 cycles, then response 11. Ack and err in the same cycle -> response 10.
- Back-to-back: read and write held continuously -> waitrequest high during BUSY/RESP; exactly one Wishbone cycle per accepted command; write wins when both are asserted.
- Reset mid-read: assert rst_in during BUSY -> wb_cyc_o=0 in the same cycle; no readdatavalid after release; next read completes normally.
